// File: rtl/decimal_entry_pkg.sv
// Shared definitions for decimal_entry: FSM state encodings and 7-segment patterns.
// Segment vectors are indexed [0:6] = a..g, active-low.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        S_TENS = 2'd0,
        S_ONES = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_E     = 7'b0110000;

    localparam logic [0:6] SEG_DIGITS [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001101,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    function automatic logic [0:6] seg_encode(input logic [3:0] digit);
        logic [0:6] seg;
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/decimal_entry_seg7_digit.sv
// One BCD digit to active-low a..g segments; codes above 9 show blank.
// Purely combinational.
module seg7_digit
    import decimal_entry_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    assign seg = seg_encode(digit);

endmodule

// File: rtl/decimal_entry.sv
// Two-digit BCD keypad entry: Enter edges commit D as tens then ones, Value = tens*10+ones.
// Optional segment echo of the entered digits when DECIMAL_ENTRY_ECHO_EN is defined.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] D,
    input  logic       Enter,
    input  logic       Clear,
    output logic [6:0] Value,
    output logic       Valid,
    output logic       Error,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   last_q;
    logic                   commit;

    state_t     state;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] tens_x10;
    logic       digit_ok;

    // fill_q marks stages that hold real post-reset samples; last_q only tracks the
    // synchroniser once it is full, so an Enter held through Reset never commits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            fill_q <= '0;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Enter};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (fill_q[SYNC_STAGES-1]) begin
                last_q <= sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign commit   = sync_q[SYNC_STAGES-1] & ~last_q;
    assign digit_ok = (D <= 4'd9);

    always_comb begin
        tens_x10 = ({3'b000, tens} << 3) + ({3'b000, tens} << 1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_TENS;
            tens  <= 4'd0;
            ones  <= 4'd0;
            Value <= 7'd0;
            Valid <= 1'b0;
            Error <= 1'b0;
        end else if (Clear) begin
            state <= S_TENS;
            tens  <= 4'd0;
            ones  <= 4'd0;
            Valid <= 1'b0;
            Error <= 1'b0;
        end else if (commit && (state != S_ERR)) begin
            if (!digit_ok) begin
                state <= S_ERR;
                Valid <= 1'b0;
                Error <= 1'b1;
            end else begin
                case (state)
                    S_TENS: begin
                        tens  <= D;
                        state <= S_ONES;
                    end
                    S_ONES: begin
                        ones  <= D;
                        Value <= tens_x10 + {3'b000, D};
                        Valid <= 1'b1;
                        state <= S_DONE;
                    end
                    S_DONE: begin
                        // A new entry starts; the finished Value stays visible.
                        tens  <= D;
                        ones  <= 4'd0;
                        Valid <= 1'b0;
                        state <= S_ONES;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

`ifdef DECIMAL_ENTRY_ECHO_EN
    logic [0:6] tens_seg;
    logic [0:6] ones_seg;

    seg7_digit u_tens_seg (
        .digit (tens),
        .seg   (tens_seg)
    );

    seg7_digit u_ones_seg (
        .digit (ones),
        .seg   (ones_seg)
    );

    always_comb begin
        HEX1 = SEG_BLANK;
        HEX0 = SEG_BLANK;
        case (state)
            S_ONES: begin
                HEX1 = tens_seg;
            end
            S_DONE: begin
                HEX1 = tens_seg;
                HEX0 = ones_seg;
            end
            S_ERR: begin
                HEX1 = SEG_E;
                HEX0 = SEG_E;
            end
            default: begin
                HEX1 = SEG_BLANK;
                HEX0 = SEG_BLANK;
            end
        endcase
    end
`else
    assign HEX1 = SEG_BLANK;
    assign HEX0 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_decimal_entry.sv
// Scenario bench for decimal_entry with a digit-level reference model and random entry sequences.
module tb_decimal_entry;

    localparam int SYNC = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] D     = 4'd0;
    logic       Enter = 1'b0;
    logic       Clear = 1'b0;
    logic [6:0] Value;
    logic       Valid;
    logic       Error;
    logic [0:6] HEX1;
    logic [0:6] HEX0;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = expecting tens, 1 = expecting ones, 2 = number complete.
    int m_phase = 0;
    bit m_err   = 1'b0;
    int m_tens  = 0;
    int m_ones  = 0;
    int m_value = 0;

    logic [0:6] ref_digits [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100
    };
    logic [0:6] ref_blank = 7'b1111111;
    logic [0:6] ref_e     = 7'b0110000;

    decimal_entry #(.SYNC_STAGES(SYNC)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .D     (D),
        .Enter (Enter),
        .Clear (Clear),
        .Value (Value),
        .Valid (Valid),
        .Error (Error),
        .HEX1  (HEX1),
        .HEX0  (HEX0)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_phase = 0; m_err = 1'b0; m_tens = 0; m_ones = 0; m_value = 0;
    endfunction

    function automatic void model_clear();
        m_phase = 0; m_err = 1'b0; m_tens = 0; m_ones = 0;
    endfunction

    function automatic void model_commit(input int d);
        if (m_err) return;
        if (d > 9) begin
            m_err = 1'b1;
        end else if (m_phase == 1) begin
            m_ones  = d;
            m_value = m_tens * 10 + d;
            m_phase = 2;
        end else begin
            m_tens  = d;
            m_ones  = 0;
            m_phase = 1;
        end
    endfunction

    function automatic logic exp_valid();
        return (!m_err && m_phase == 2);
    endfunction

    function automatic logic [0:6] exp_hex1();
        logic [0:6] s;
        s = ref_blank;
`ifdef DECIMAL_ENTRY_ECHO_EN
        if (m_err) s = ref_e;
        else if (m_phase >= 1) s = ref_digits[m_tens];
`endif
        return s;
    endfunction

    function automatic logic [0:6] exp_hex0();
        logic [0:6] s;
        s = ref_blank;
`ifdef DECIMAL_ENTRY_ECHO_EN
        if (m_err) s = ref_e;
        else if (m_phase == 2) s = ref_digits[m_ones];
`endif
        return s;
    endfunction

    task automatic do_commit(input int d);
        @(negedge Clock);
        D = 4'(d);
        Enter = 1'b1;
        repeat (SYNC + 2) @(negedge Clock);
        Enter = 1'b0;
        repeat (SYNC + 2) @(negedge Clock);
        model_commit(d);
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        total++; if (Value !== 7'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", Value); end
        total++; if (Valid !== 1'b0 || Error !== 1'b0) begin bad++; $display("FAIL reset_flags got valid=%b error=%b exp 0 0", Valid, Error); end
        total++; if (HEX1 !== ref_blank || HEX0 !== ref_blank) begin bad++; $display("FAIL reset_hex got=%b/%b exp=%b", HEX1, HEX0, ref_blank); end
        Reset = 1'b0;
        model_reset();
        repeat (SYNC + 3) @(negedge Clock);
        total++; if (Valid !== 1'b0 || Value !== 7'd0) begin bad++; $display("FAIL post_reset got valid=%b value=%0d exp 0 0", Valid, Value); end
    endtask

    task automatic test_basic();
        do_commit(4);
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL basic_tens_valid got=%b exp=0", Valid); end
        total++; if (HEX1 !== exp_hex1()) begin bad++; $display("FAIL basic_tens_hex1 got=%b exp=%b", HEX1, exp_hex1()); end
        do_commit(7);
        total++; if (Value !== 7'b0101111) begin bad++; $display("FAIL basic_value got=%0d exp=47", Value); end
        total++; if (Valid !== 1'b1 || Error !== 1'b0) begin bad++; $display("FAIL basic_flags got valid=%b error=%b exp 1 0", Valid, Error); end
`ifdef DECIMAL_ENTRY_ECHO_EN
        total++; if (HEX1 !== 7'b1001100 || HEX0 !== 7'b0001101) begin bad++; $display("FAIL basic_hex got=%b/%b exp=1001100/0001101", HEX1, HEX0); end
`else
        total++; if (HEX1 !== ref_blank || HEX0 !== ref_blank) begin bad++; $display("FAIL basic_hex got=%b/%b exp=1111111", HEX1, HEX0); end
`endif
    endtask

    task automatic test_restart();
        do_commit(9);
        do_commit(9);
        total++; if (Value !== 7'd99 || Valid !== 1'b1) begin bad++; $display("FAIL restart_99 got value=%0d valid=%b exp 99 1", Value, Valid); end
        do_commit(2);
        total++; if (Value !== 7'd99 || Valid !== 1'b0) begin bad++; $display("FAIL restart_hold got value=%0d valid=%b exp 99 0", Value, Valid); end
        total++; if (HEX1 !== exp_hex1() || HEX0 !== exp_hex0()) begin bad++; $display("FAIL restart_hex got=%b/%b exp=%b/%b", HEX1, HEX0, exp_hex1(), exp_hex0()); end
        do_commit(5);
        total++; if (Value !== 7'd25 || Valid !== 1'b1) begin bad++; $display("FAIL restart_25 got value=%0d valid=%b exp 25 1", Value, Valid); end
    endtask

    task automatic test_error();
        do_commit(3);
        do_commit(12);
        total++; if (Error !== 1'b1 || Valid !== 1'b0) begin bad++; $display("FAIL err_flags got error=%b valid=%b exp 1 0", Error, Valid); end
        total++; if (Value !== 7'd25) begin bad++; $display("FAIL err_value got=%0d exp=25", Value); end
        total++; if (HEX1 !== exp_hex1() || HEX0 !== exp_hex0()) begin bad++; $display("FAIL err_hex got=%b/%b exp=%b/%b", HEX1, HEX0, exp_hex1(), exp_hex0()); end
        do_commit(5);
        do_commit(6);
        total++; if (Error !== 1'b1 || Value !== 7'd25) begin bad++; $display("FAIL err_ignore got error=%b value=%0d exp 1 25", Error, Value); end
        do_clear();
        total++; if (Error !== 1'b0 || Valid !== 1'b0) begin bad++; $display("FAIL err_clear got error=%b valid=%b exp 0 0", Error, Valid); end
    endtask

    task automatic test_latency_held();
        int  cnt;
        bool_loop: begin end
        do_commit(1);
        @(posedge Clock);
        #1;
        D = 4'd8;
        Enter = 1'b1;
        cnt = 0;
        while (Value === 7'd25 && cnt < 20) begin
            @(posedge Clock);
            #1;
            cnt++;
        end
        total++; if (cnt !== SYNC + 1) begin bad++; $display("FAIL latency got=%0d exp=%0d clocks", cnt, SYNC + 1); end
        model_commit(8);
        total++; if (Value !== 7'(m_value)) begin bad++; $display("FAIL latency_value got=%0d exp=%0d", Value, m_value); end
        repeat (50) @(posedge Clock);
        #1;
        total++; if (Valid !== 1'b1 || Value !== 7'd18) begin bad++; $display("FAIL held_once got valid=%b value=%0d exp 1 18", Valid, Value); end
        Enter = 1'b0;
        repeat (SYNC + 3) @(negedge Clock);
    endtask

    task automatic test_clear_priority();
        do_commit(4);
        @(posedge Clock);
        #1;
        D = 4'd9;
        Enter = 1'b1;
        repeat (SYNC) @(posedge Clock);
        #1;
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        model_clear();
        total++; if (Valid !== 1'b0 || Value !== 7'd18 || Error !== 1'b0) begin bad++; $display("FAIL clear_prio got valid=%b value=%0d error=%b exp 0 18 0", Valid, Value, Error); end
        total++; if (HEX1 !== exp_hex1()) begin bad++; $display("FAIL clear_prio_hex1 got=%b exp=%b", HEX1, exp_hex1()); end
        repeat (4) @(negedge Clock);
        Enter = 1'b0;
        repeat (SYNC + 3) @(negedge Clock);
        do_commit(7);
        do_commit(2);
        total++; if (Value !== 7'd72 || Valid !== 1'b1) begin bad++; $display("FAIL clear_then_72 got value=%0d valid=%b exp 72 1", Value, Valid); end
    endtask

    task automatic test_async_reset();
        do_commit(5);
        @(negedge Clock);
        D = 4'd8;
        Enter = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        total++; if (Value !== 7'd0 || Valid !== 1'b0 || Error !== 1'b0) begin bad++; $display("FAIL async_reset got value=%0d valid=%b error=%b exp 0 0 0", Value, Valid, Error); end
        total++; if (HEX1 !== ref_blank || HEX0 !== ref_blank) begin bad++; $display("FAIL async_reset_hex got=%b/%b exp=%b", HEX1, HEX0, ref_blank); end
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        repeat (10) @(negedge Clock);
        Enter = 1'b0;
        repeat (SYNC + 3) @(negedge Clock);
        do_commit(2);
        do_commit(3);
        total++; if (Value !== 7'd23 || Valid !== 1'b1) begin bad++; $display("FAIL reset_no_commit got value=%0d valid=%b exp 23 1", Value, Valid); end
    endtask

    task automatic test_random();
        int r;
        int d;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0 || (m_err && r < 8)) begin
                do_clear();
            end else begin
                d = (r < 3) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                do_commit(d);
            end
            total++;
            if (Value !== 7'(m_value) || Valid !== exp_valid() || Error !== m_err
                || HEX1 !== exp_hex1() || HEX0 !== exp_hex0()) begin
                bad++;
                $display("FAIL random[%0d] got value=%0d valid=%b error=%b hex=%b/%b exp %0d %b %b %b/%b",
                         i, Value, Valid, Error, HEX1, HEX0, m_value, exp_valid(), m_err, exp_hex1(), exp_hex0());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_error();
        test_latency_held();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decimal_entry.md
DECIMAL_ENTRY -- requirements
Module: decimal_entry

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, setting the number of flip-flop stages synchronising Enter (minimum 2).
REQ-002 SHALL have port Clock, input, 1, the single rising-edge clock for all state.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port D, input, 4, the BCD digit presented by the switches.
REQ-005 SHALL have port Enter, input, 1, an asynchronous level from a key; each rising edge commits D.
REQ-006 SHALL have port Clear, input, 1, a synchronous abort that returns the block to waiting for a tens digit.
REQ-007 SHALL have port Value, output, 7, the binary result 0..99.
REQ-008 SHALL have port Valid, output, 1, high while Value holds a completed entry.
REQ-009 SHALL have port Error, output, 1, high while an invalid digit is latched.
REQ-010 SHALL have ports HEX1 and HEX0, output, 7 each, indexed [0:6], active-low segments a..g for the tens and ones echo.

Function
REQ-011 SHALL detect a commit as a 0->1 transition at the last synchroniser stage, one cycle wide; commit latency is SYNC_STAGES+1 clocks after Enter rises.
REQ-012 SHALL implement FSM states S_TENS, S_ONES, S_DONE and S_ERR.
REQ-013 On commit in S_TENS with D<=9: SHALL latch tens=D and go to S_ONES.
REQ-014 On commit in S_ONES with D<=9: SHALL latch ones=D, register Value=tens*10+ones on the same edge, and go to S_DONE.
REQ-015 SHALL compute tens*10 as (tens<<3)+(tens<<1) in at least 7 bits; the result never exceeds 99.
REQ-016 On commit in S_DONE with D<=9: SHALL start a new entry by latching tens=D, clearing ones, and going to S_ONES; Value holds its previous contents.
REQ-017 On commit of D>=10 in any non-error state: SHALL go to S_ERR and leave Value unchanged.
REQ-018 In S_ERR: SHALL ignore commits; only Clear or Reset leaves the state.
REQ-019 On Clear=1: SHALL go to S_TENS and zero tens and ones, keeping Value; Clear has priority over a commit in the same cycle.
REQ-020 Outputs SHALL be registered or decoded only from state: Valid=1 only in S_DONE, and Error=1 only in S_ERR.
REQ-021 A held-high Enter SHALL produce exactly one commit, and Enter pulses shorter than one clock need not be captured.

Reset
REQ-022 While Reset=1: SHALL force state S_TENS, tens=0, ones=0, Value=0, Valid=0, Error=0, all synchroniser stages 0, and HEX1/HEX0=7'b1111111.
REQ-023 SHALL let Reset asserted mid-entry discard partial digits, with no commit generated on release even if Enter is high.

Configuration
REQ-024 With macro DECIMAL_ENTRY_ECHO_EN defined: SHALL drive HEX1 with the tens digit in S_ONES/S_DONE and HEX0 with the ones digit in S_DONE, blank (1111111) otherwise, and both show "E" (0110000) in S_ERR.
REQ-025 Without DECIMAL_ENTRY_ECHO_EN: SHALL tie HEX1 and HEX0 to 1111111 and omit the decode logic.

Structure
REQ-026 A shared package SHALL hold the FSM state encodings, the blank and "E" segment constants, and the 0..9 segment table.
REQ-027 SHALL use one sub-module, seg7_digit (4-bit in, [0:6] active-low out, blank for >9), instantiated twice under DECIMAL_ENTRY_ECHO_EN.

Verification
REQ-028 Reset, commit D=4, commit D=7 -> Value=47 (0101111), Valid=1, Error=0, HEX1=1001100, HEX0=0001101.
REQ-029 Commit D=9, commit D=9 -> Value=99; then commit D=2 -> Valid=0, Value still 99, state S_ONES.
REQ-030 Commit D=3, commit D=12 -> Error=1, Value unchanged, HEX1/HEX0=0110000; further commits are ignored; Clear -> S_TENS, Error=0.
REQ-031 Enter held high 50 cycles -> exactly one commit; Enter rising to the first Value update takes exactly SYNC_STAGES+1 clocks.
REQ-032 Clear and a commit in the same cycle -> S_TENS, no digit latched; Reset asserted in S_ONES -> all outputs at reset values immediately, asynchronously.
